// File: rtl/regfile_operand_fetch.sv
// +----------------------------------------------------------------------------+
// | regfile_operand_fetch: issue-side reader for a synchronous-read register    |
// | file. It bypasses writes the array has not yet exposed and holds operands.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module regfile_operand_fetch #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int TAGW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [AW-1:0]   req_rs1_i,
  input  logic [AW-1:0]   req_rs2_i,
  input  logic [TAGW-1:0] req_tag_i,
  output logic [AW-1:0]   rf_rs1_addr_o,
  output logic [AW-1:0]   rf_rs2_addr_o,
  input  logic [XLEN-1:0] rf_rs1_data_i,
  input  logic [XLEN-1:0] rf_rs2_data_i,
  input  logic            wb_wen_i,
  input  logic [AW-1:0]   wb_waddr_i,
  input  logic [XLEN-1:0] wb_wdata_i,
  output logic            op_valid_o,
  input  logic            op_ready_i,
  output logic [XLEN-1:0] op_rs1_data_o,
  output logic [XLEN-1:0] op_rs2_data_o,
  output logic [TAGW-1:0] op_tag_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   rs1_q, rs2_q;
  logic [TAGW-1:0] tag_q;
  logic            wb_wen_q;
  logic [AW-1:0]   wb_waddr_q;
  logic [XLEN-1:0] wb_wdata_q;
  logic [XLEN-1:0] hold1_q, hold1_d, hold2_q, hold2_d;
  logic            w_accept;
  logic            w_hold_en;
  logic [XLEN-1:0] w_fetch1, w_fetch2;

  assign req_ready_o   = (state_q == S_IDLE) || op_ready_i;
  assign w_accept      = req_valid_i && req_ready_o;
  assign rf_rs1_addr_o = req_rs1_i;
  assign rf_rs2_addr_o = req_rs2_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:          if (w_accept) state_d = S_FETCH;
      S_FETCH, S_HOLD: begin
        if (op_ready_i) state_d = w_accept ? S_FETCH : S_IDLE;
        else            state_d = S_HOLD;
      end
      default:         state_d = S_IDLE;
    endcase
  end

  // Array data misses the write retired in the accept cycle, so patch it from wb_*_q.
  always_comb begin
    w_fetch1 = rf_rs1_data_i;
    if (rs1_q == '0)                               w_fetch1 = '0;
    else if (wb_wen_q && (wb_waddr_q == rs1_q))    w_fetch1 = wb_wdata_q;
    w_fetch2 = rf_rs2_data_i;
    if (rs2_q == '0)                               w_fetch2 = '0;
    else if (wb_wen_q && (wb_waddr_q == rs2_q))    w_fetch2 = wb_wdata_q;
  end

  always_comb begin
    op_valid_o    = (state_q != S_IDLE);
    op_tag_o      = tag_q;
    op_rs1_data_o = '0;
    op_rs2_data_o = '0;
    if (state_q == S_FETCH) begin
      op_rs1_data_o = w_fetch1;
      op_rs2_data_o = w_fetch2;
    end else if (state_q == S_HOLD) begin
      op_rs1_data_o = hold1_q;
      op_rs2_data_o = hold2_q;
    end
  end

  // A write landing on the capture edge must win over the captured value.
  assign w_hold_en = (state_q == S_HOLD) || ((state_q == S_FETCH) && !op_ready_i);

  always_comb begin
    hold1_d = hold1_q;
    hold2_d = hold2_q;
    if ((state_q == S_FETCH) && !op_ready_i) begin
      hold1_d = w_fetch1;
      hold2_d = w_fetch2;
    end
    if (w_hold_en && wb_wen_i && (wb_waddr_i == rs1_q) && (rs1_q != '0)) hold1_d = wb_wdata_i;
    if (w_hold_en && wb_wen_i && (wb_waddr_i == rs2_q) && (rs2_q != '0)) hold2_d = wb_wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_q      <= '0;
      rs2_q      <= '0;
      tag_q      <= '0;
      wb_wen_q   <= 1'b0;
      wb_waddr_q <= '0;
      wb_wdata_q <= '0;
      hold1_q    <= '0;
      hold2_q    <= '0;
    end else begin
      if (w_accept) begin
        rs1_q <= req_rs1_i;
        rs2_q <= req_rs2_i;
        tag_q <= req_tag_i;
      end
      wb_wen_q   <= wb_wen_i;
      wb_waddr_q <= wb_waddr_i;
      wb_wdata_q <= wb_wdata_i;
      hold1_q    <= hold1_d;
      hold2_q    <= hold2_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_operand_fetch.sv
// +----------------------------------------------------------------------------+
// | tb_regfile_operand_fetch: directed bench with a synchronous-read RF model.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_regfile_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [4:0]  req_rs1, req_rs2;
  logic [7:0]  req_tag;
  logic [4:0]  rf_a1, rf_a2;
  logic [31:0] rf_d1, rf_d2;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        op_valid, op_ready;
  logic [31:0] op_d1, op_d2;
  logic [7:0]  op_tag;
  logic        mem_clr;
  logic [31:0] mem [32];

  int checks   = 0;
  int failures = 0;

  regfile_operand_fetch #(.XLEN(32), .AW(5), .TAGW(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_tag_i(req_tag),
    .rf_rs1_addr_o(rf_a1), .rf_rs2_addr_o(rf_a2),
    .rf_rs1_data_i(rf_d1), .rf_rs2_data_i(rf_d2),
    .wb_wen_i(wb_wen), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
    .op_valid_o(op_valid), .op_ready_i(op_ready),
    .op_rs1_data_o(op_d1), .op_rs2_data_o(op_d2), .op_tag_o(op_tag)
  );

  always #5 clk = ~clk;

  // Plain array, x0 included, so the DUT alone is responsible for x0 reading as zero.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (wb_wen) begin
      mem[wb_waddr] <= wb_wdata;
    end
    rf_d1 <= mem[rf_a1];
    rf_d2 <= mem[rf_a2];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_tag = '0;
    wb_wen = 1'b0; wb_waddr = '0; wb_wdata = '0;
  endtask

  initial begin
    rst = 1'b1; mem_clr = 1'b1; op_ready = 1'b1;
    idle_in();
    tick(); tick();
    #1;
    chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_op_d1", op_d1, 32'd0);
    chk("rst_op_tag", {24'd0, op_tag}, 32'd0);
    rst = 1'b0; mem_clr = 1'b0;
    tick();

    // Basic read: x5 written, two idle cycles, then request.
    wb_wen = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'h0000_1234;
    tick();
    idle_in();
    tick(); tick();
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd0; req_tag = 8'h11;
    #1;
    chk("basic_req_ready", {31'd0, req_ready}, 32'd1);
    chk("basic_rf_addr", {27'd0, rf_a1}, 32'd5);
    tick();
    idle_in();
    #1;
    chk("basic_op_valid", {31'd0, op_valid}, 32'd1);
    chk("basic_rs1", op_d1, 32'h0000_1234);
    chk("basic_rs2", op_d2, 32'd0);
    chk("basic_tag", {24'd0, op_tag}, 32'h11);
    tick();
    #1;
    chk("basic_back_idle", {31'd0, op_valid}, 32'd0);

    // Write and accepted read of x7 in the same cycle.
    wb_wen = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'hAA;
    req_valid = 1'b1; req_rs1 = 5'd7; req_rs2 = 5'd7; req_tag = 8'h22;
    tick();
    idle_in();
    #1;
    chk("byp_rs1", op_d1, 32'hAA);
    chk("byp_rs2", op_d2, 32'hAA);
    chk("byp_tag", {24'd0, op_tag}, 32'h22);
    tick();

    // Stall: x3=1, request rs1=3/rs2=6, op_ready low for 4 cycles.
    wb_wen = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'd1;
    tick();
    idle_in();
    tick();
    req_valid = 1'b1; req_rs1 = 5'd3; req_rs2 = 5'd6; req_tag = 8'h33;
    tick();
    // Stall cycle 1 (FETCH); a refused request and a write to x6 on the capture edge.
    op_ready = 1'b0;
    req_rs1 = 5'd9; req_rs2 = 5'd9; req_tag = 8'h99;
    wb_wen = 1'b1; wb_waddr = 5'd6; wb_wdata = 32'h66;
    #1;
    chk("stall1_valid", {31'd0, op_valid}, 32'd1);
    chk("stall1_ready", {31'd0, req_ready}, 32'd0);
    chk("stall1_rs1", op_d1, 32'd1);
    chk("stall1_rs2", op_d2, 32'd0);
    tick();
    // Stall cycle 2 (HOLD): write x3=2.
    wb_waddr = 5'd3; wb_wdata = 32'd2;
    #1;
    chk("stall2_ready", {31'd0, req_ready}, 32'd0);
    chk("stall2_rs1", op_d1, 32'd1);
    chk("stall2_rs2_capture", op_d2, 32'h66);
    tick();
    wb_wen = 1'b0;
    #1;
    chk("stall3_rs1", op_d1, 32'd2);
    chk("stall3_tag", {24'd0, op_tag}, 32'h33);
    tick();
    #1;
    chk("stall4_rs1", op_d1, 32'd2);
    chk("stall4_ready", {31'd0, req_ready}, 32'd0);
    tick();
    idle_in();
    op_ready = 1'b1;
    #1;
    chk("stall_rel_valid", {31'd0, op_valid}, 32'd1);
    chk("stall_rel_ready", {31'd0, req_ready}, 32'd1);
    chk("stall_rel_rs1", op_d1, 32'd2);
    chk("stall_rel_rs2", op_d2, 32'h66);
    tick();
    #1;
    chk("stall_done_idle", {31'd0, op_valid}, 32'd0);

    // Streaming: x1..x4 = 0x10..0x40, four back-to-back requests.
    for (int i = 1; i <= 4; i++) begin
      wb_wen = 1'b1; wb_waddr = 5'(i); wb_wdata = 32'(16 * i);
      tick();
    end
    idle_in();
    tick();
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) begin
        req_valid = 1'b1; req_rs1 = 5'(i); req_rs2 = 5'(5 - i); req_tag = 8'(i);
      end else begin
        idle_in();
      end
      #1;
      if (i > 1) begin
        chk($sformatf("strm%0d_valid", i - 1), {31'd0, op_valid}, 32'd1);
        chk($sformatf("strm%0d_tag", i - 1), {24'd0, op_tag}, 32'(i - 1));
        chk($sformatf("strm%0d_rs1", i - 1), op_d1, 32'(16 * (i - 1)));
        chk($sformatf("strm%0d_rs2", i - 1), op_d2, 32'(16 * (6 - i)));
      end
      tick();
    end
    #1;
    chk("strm_end_idle", {31'd0, op_valid}, 32'd0);

    // x0: write all-ones to x0, read x0 in the same cycle and two cycles later.
    wb_wen = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'hFFFF_FFFF;
    req_valid = 1'b1; req_rs1 = 5'd0; req_rs2 = 5'd0; req_tag = 8'h44;
    tick();
    idle_in();
    #1;
    chk("x0_same_rs1", op_d1, 32'd0);
    chk("x0_same_rs2", op_d2, 32'd0);
    tick();
    req_valid = 1'b1; req_rs1 = 5'd0; req_rs2 = 5'd0; req_tag = 8'h45;
    tick();
    idle_in();
    #1;
    chk("x0_later_valid", {31'd0, op_valid}, 32'd1);
    chk("x0_later_rs1", op_d1, 32'd0);
    chk("x0_later_rs2", op_d2, 32'd0);
    tick();

    // Reset while holding an in-flight request.
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd0; req_tag = 8'h55;
    op_ready = 1'b0;
    tick();
    idle_in();
    tick();
    #1;
    chk("pre_rst_hold_rs1", op_d1, 32'h0000_1234);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, op_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_rs1", op_d1, 32'd0);
    chk("mid_rst_tag", {24'd0, op_tag}, 32'd0);
    tick();
    rst = 1'b0;
    op_ready = 1'b1;
    tick(); tick();
    #1;
    chk("post_rst_idle", {31'd0, op_valid}, 32'd0);
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd0; req_tag = 8'h66;
    tick();
    idle_in();
    #1;
    chk("post_rst_rs1", op_d1, 32'h0000_1234);
    chk("post_rst_tag", {24'd0, op_tag}, 32'h66);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_operand_fetch.md
# regfile_operand_fetch

Issue-side reader for the synchronous-read integer register file. It accepts one decoded operand request per cycle (rs1, rs2, tag), drives the register file read addresses, and absorbs the register file's one-cycle read latency. It bypasses write-port traffic the array has not yet exposed, and holds operands stable under downstream back-pressure. It sits between decode and execute, alongside the write-back stage that owns the register file write port.

## Interface
- `XLEN`, 32, operand width
- `AW`, 5, register address width
- `TAGW`, 8, width of opaque request tag carried with operands

- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  operand request valid
- `req_ready`  out  1  request accepted when `req_valid && req_ready`
- `req_rs1`, `req_rs2`  in  AW  source register indices
- `req_tag`  in  TAGW  passthrough tag
- `rf_rs1_addr`, `rf_rs2_addr`  out  AW  register file read addresses (combinational copies of `req_rs1`/`req_rs2`)
- `rf_rs1_data`, `rf_rs2_data`  in  XLEN  register file read data, valid one cycle after address
- `wb_wen`  in  1  snoop of register file write enable
- `wb_waddr`  in  AW  snoop of write address
- `wb_wdata`  in  XLEN  snoop of write data
- `op_valid`  out  1  operands valid
- `op_ready`  in  1  downstream accepts when `op_valid && op_ready`
- `op_rs1_data`, `op_rs2_data`  out  XLEN  operand values
- `op_tag`  out  TAGW  tag of presented operands

## Operation
- States: IDLE (nothing in flight), FETCH (operands arriving from register file this cycle), HOLD (operands held in local registers).
- `op_valid` = state != IDLE. `req_ready` = (state == IDLE) || `op_ready`.
- On accept: latch `req_rs1`, `req_rs2`, `req_tag` into `rs1_q`, `rs2_q`, `tag_q`. Next state is FETCH.
- Every cycle: register `wb_wen`/`wb_waddr`/`wb_wdata` into `wb_*_q`.
- FETCH operand value, per source: if `rsX_q == 0`, the value is 0. Else, if `wb_wen_q && wb_waddr_q == rsX_q`, the value is `wb_wdata_q`. Otherwise it is `rf_rsX_data`.
- Transitions out of FETCH:
  - `op_ready` with a new accept: FETCH.
  - `op_ready` without an accept: IDLE.
  - `!op_ready`: capture FETCH values into hold registers and go to HOLD.
- HOLD: outputs come from the hold registers.
  - At every edge in HOLD, and on the FETCH→HOLD capture edge: if `wb_wen && wb_waddr == rsX_q && rsX_q != 0`, the hold register takes `wb_wdata`. This write priority overrides the capture value.
  - `op_ready` with a new accept: FETCH.
  - `op_ready` without an accept: IDLE.
  - `!op_ready`: stay in HOLD.
- Visibility rule: operands presented in cycle k reflect every write with `wb_wen` high in cycles < k. A write in cycle k itself is not visible; the hazard unit handles that case.
- Writes to x0 are never forwarded. Reads of x0 always return 0.
- Tag rides unmodified with its operands.

## Timing
- Latency: accept at edge ending cycle T gives `op_valid` in T+1.
- Throughput: 1 request per cycle while `op_ready` is held high.
- All outputs except `rf_rs*_addr` and `req_ready` are registered or muxed from registered state plus `rf_rs*_data`. No combinational path from `wb_*` to `op_*`.
- Reset values: state IDLE, `op_valid` 0, `req_ready` 1, `op_rs1_data`/`op_rs2_data` 0, `op_tag` 0, hold registers 0, `wb_wen_q` 0.
- Reset asserted mid-FETCH or mid-HOLD drops the in-flight request. Nothing is presented after release until a new accept.
- Back-pressure may persist indefinitely. Operands track writes throughout the stall.
- `req_valid` without `req_ready` has no effect. `rf_rs*_addr` still toggles and the returned data is ignored.

## Test plan
- Reset: assert `rst` during traffic → same cycle `op_valid`=0, `req_ready`=1, `op_*` = 0; after release, no op until a request.
- Basic read: write x5=0x00001234, idle 2 cycles, request rs1=5, rs2=0, tag=0x11 → next cycle `op_valid`=1, rs1=0x00001234, rs2=0, tag=0x11.
- Same-cycle write/read: cycle T has `wb_wen` x7=0xAA and an accepted request rs1=7, rs2=7 → T+1 both operands 0xAA (bypass from `wb_*_q`).
- Stall update: x3=1, request rs1=3, `op_ready`=0 for 4 cycles, write x3=2 in stall cycle 2 → from stall cycle 3 on, `op_rs1_data`=2; `req_ready`=0 throughout stall; op accepted when `op_ready` rises.
- Streaming: 4 back-to-back requests (tags 1..4, rs1=1..4 preloaded 0x10..0x40), `op_ready`=1 → 4 consecutive `op_valid` cycles, in-order tags, correct data; then IDLE.
- x0: write x0=0xFFFFFFFF, then request rs1=0, rs2=0 in the same cycle as the write and again 2 cycles later → operands 0 both times.
